// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - step-index constants and phase type for the restoring divider
//
// Package div_pkg
//   div_phase_e      : decoded phase of the step counter
//   STEP_LOAD        : step index of the operand load (0)
//   STEP_ITER_FIRST  : step index of the first shift/subtract iteration (1)
//   step_fix(w)      : step index of the sign fix-up (w+1)
//   step_done(w)     : step index that raises done_sig (w+2)
//   step_clr(w)      : step index that drops done_sig and rewinds (w+3)
//   step_cnt_w(w)    : step counter width, $clog2(w+4)
package div_pkg;

  typedef enum logic [2:0] {
    PH_LOAD,
    PH_ITER,
    PH_FIX,
    PH_DONE,
    PH_CLR
  } div_phase_e;

  localparam int STEP_LOAD       = 0;
  localparam int STEP_ITER_FIRST = 1;

  function automatic int step_fix(input int width);
    return width + 1;
  endfunction

  function automatic int step_done(input int width);
    return width + 2;
  endfunction

  function automatic int step_clr(input int width);
    return width + 3;
  endfunction

  function automatic int step_cnt_w(input int width);
    return $clog2(width + 4);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational shift/trial-subtract iteration
//
// Ports
//   r      in  WIDTH  partial remainder (always < divisor, so WIDTH bits suffice)
//   q      in  WIDTH  dividend/quotient shift register
//   d      in  WIDTH  divisor magnitude
//   r_next out WIDTH  partial remainder after this step
//   q_next out WIDTH  quotient register after this step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] t;

  always_comb begin
    t = {r, q[WIDTH-1]} - {1'b0, d};
    if (t[WIDTH] == 1'b0) begin
      r_next = t[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      // Restore path: the remainder is below the divisor (at most 2^(WIDTH-1)),
      // so its top bit is zero and dropping it on the shift loses nothing.
      r_next = {r[WIDTH-2:0], q[WIDTH-1]};
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/restoring_divider_module.sv
// rtl/restoring_divider_module.sv - signed sequential restoring divider, one iteration per clock
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   start_sig  in   1      level request, held high for the whole operation; low pauses
//   dividend   in   WIDTH  signed dividend, sampled at the load step
//   divisor    in   WIDTH  signed divisor, sampled at the load step
//   done_sig   out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  signed quotient, truncated toward zero
//   remainder  out  WIDTH  signed remainder, sign of dividend
//   div_zero   out  1      last operation had divisor == 0
//   overflow   out  1      last operation was MIN / -1
// Optional (macro DIV_DEBUG_PORTS_EN)
//   SQ_r       out  WIDTH+1  internal partial remainder
//   SQ_q       out  WIDTH    internal quotient register
//   SQ_d       out  WIDTH    internal divisor magnitude
module restoring_divider_module
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_sig,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
`ifdef DIV_DEBUG_PORTS_EN
  ,
  output logic [WIDTH:0]   SQ_r,
  output logic [WIDTH-1:0] SQ_q,
  output logic [WIDTH-1:0] SQ_d
`endif
);

  localparam int CW = step_cnt_w(WIDTH);
  localparam logic [CW-1:0] S_LOAD       = CW'(STEP_LOAD);
  localparam logic [CW-1:0] S_ITER_FIRST = CW'(STEP_ITER_FIRST);
  localparam logic [CW-1:0] S_FIX        = CW'(step_fix(WIDTH));
  localparam logic [CW-1:0] S_DONE       = CW'(step_done(WIDTH));
  localparam logic [CW-1:0] S_CLR        = CW'(step_clr(WIDTH));
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CW-1:0]    i;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             neg_dvd;
  logic             neg_dvs;
  logic             zero_dvs;
  logic             ovf_case;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  div_phase_e       phase;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_comb begin
    phase = PH_CLR;
    if (i == S_LOAD)                          phase = PH_LOAD;
    else if (i >= S_ITER_FIRST && i < S_FIX)  phase = PH_ITER;
    else if (i == S_FIX)                      phase = PH_FIX;
    else if (i == S_DONE)                     phase = PH_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i         <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      neg_dvd   <= 1'b0;
      neg_dvs   <= 1'b0;
      zero_dvs  <= 1'b0;
      ovf_case  <= 1'b0;
      done_sig  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (start_sig) begin
      case (phase)
        PH_LOAD: begin
          q        <= dividend[WIDTH-1] ? -dividend : dividend;
          d        <= divisor[WIDTH-1]  ? -divisor  : divisor;
          r        <= '0;
          neg_dvd  <= dividend[WIDTH-1];
          neg_dvs  <= divisor[WIDTH-1];
          zero_dvs <= (divisor == '0);
          ovf_case <= (dividend == MIN_VAL) && (divisor == '1);
          i        <= i + CW'(1);
        end
        PH_ITER: begin
          r <= r_next;
          q <= q_next;
          i <= i + CW'(1);
        end
        PH_FIX: begin
          if (zero_dvs) begin
            // With d==0 every trial subtract succeeds, so r ends holding
            // |dividend|; re-applying the sign reproduces the dividend.
            quotient  <= '1;
            remainder <= neg_dvd ? -r : r;
            div_zero  <= 1'b1;
            overflow  <= 1'b0;
          end else if (ovf_case) begin
            quotient  <= MIN_VAL;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= (neg_dvd ^ neg_dvs) ? -q : q;
            remainder <= neg_dvd ? -r : r;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
          i <= i + CW'(1);
        end
        PH_DONE: begin
          done_sig <= 1'b1;
          i        <= i + CW'(1);
        end
        default: begin
          done_sig <= 1'b0;
          i        <= '0;
        end
      endcase
    end
  end

`ifdef DIV_DEBUG_PORTS_EN
  assign SQ_r = {1'b0, r};
  assign SQ_q = q;
  assign SQ_d = d;
`endif

endmodule

// File: tb/tb_restoring_divider_module.sv
// tb/tb_restoring_divider_module.sv - scoreboard bench for restoring_divider_module (WIDTH=8)
module tb_restoring_divider_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_sig;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       done_sig;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;
  logic       overflow;

  always #5 clk = ~clk;

  restoring_divider_module #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_sig (start_sig),
    .dividend  (dividend),
    .divisor   (divisor),
    .done_sig  (done_sig),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done_sig === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done_sig=1 with no operation pending");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_quotient"},  32'(quotient),  32'(mon_e.q));
        chk({mon_e.nm, "_remainder"}, 32'(remainder), 32'(mon_e.r));
        chk({mon_e.nm, "_div_zero"},  32'(div_zero),  32'(mon_e.dz));
        chk({mon_e.nm, "_overflow"},  32'(overflow),  32'(mon_e.ov));
      end
    end
  end

  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input logic eo, input int pause_len);
    exp_t e;
    int   n;
    bit   seen;
    e.q = eq; e.r = er; e.dz = ez; e.ov = eo; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    start_sig = 1'b1;
    n    = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        // operands must be ignored after the load step
        dividend = ~a;
        divisor  = ~b;
      end
      if (pause_len > 0 && n == 4) begin
        start_sig = 1'b0;
        repeat (pause_len) @(negedge clk);
        n += pause_len;
        start_sig = 1'b1;
      end
      if (done_sig === 1'b1) seen = 1;
    end
    chk({nm, "_latency"}, 32'(n), 32'(11 + pause_len));
    @(negedge clk);
    start_sig = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_hold_q"}, 32'(quotient),  32'(eq));
    chk({nm, "_hold_r"}, 32'(remainder), 32'(er));
  endtask

  initial begin
    rst       = 1'b1;
    start_sig = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_quotient",  32'(quotient),  32'h0);
    chk("reset_remainder", 32'(remainder), 32'h0);
    chk("reset_flags",     32'({div_zero, overflow, done_sig}), 32'h0);

    //      name          a      b      quot   rem    dz    ov  pause
    run_op("p100_p7",   8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, 0);
    run_op("m100_p7",   8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, 0);
    run_op("p100_m7",   8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 0);
    run_op("m100_m7",   8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 0);
    run_op("min_m1",    8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 0);
    run_op("min_p1",    8'h80,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 0);
    run_op("p5_zero",   8'd5,   8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 0);
    run_op("m5_zero",   8'hFB,  8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0, 0);
    run_op("p127_p1",   8'h7F,  8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 0);
    run_op("min_p7",    8'h80,  8'd7,  8'hEE, 8'hFE, 1'b0, 1'b0, 0);
    run_op("p3_p7",     8'd3,   8'd7,  8'h00, 8'h03, 1'b0, 1'b0, 0);
    run_op("min_min",   8'h80,  8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 0);
    run_op("p127_min",  8'h7F,  8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 0);
    run_op("pause",     8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, 3);

    // Abort mid-operation with reset at iteration step 5.
    @(negedge clk);
    dividend  = 8'd100;
    divisor   = 8'd7;
    start_sig = 1'b1;
    repeat (5) @(negedge clk);
    rst       = 1'b1;
    start_sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient",  32'(quotient),  32'h0);
    chk("abort_remainder", 32'(remainder), 32'h0);
    chk("abort_flags",     32'({div_zero, overflow, done_sig}), 32'h0);
    repeat (15) @(negedge clk);

    run_op("after_abort", 8'd20, 8'd3, 8'h06, 8'h02, 1'b0, 1'b0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
